// File: rtl/rad4_mul_arbiter.sv
// Round-robin front end sharing one combinational radix-4 Booth multiplier.
// Operands and product are registered on both sides of the multiplier.
module rad4_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0]   req_mltplr_i,
   input  logic [NUM_REQ*WIDTH-1:0]   req_mltplcnd_i,
   output logic [NUM_REQ-1:0]         rsp_valid_o,
   input  logic [NUM_REQ-1:0]         rsp_ready_i,
   output logic [2*WIDTH-1:0]         rsp_prdct_o,
   output logic [WIDTH-1:0]           mul_mltplr_o,
   output logic [WIDTH-1:0]           mul_mltplcnd_o,
   input  logic [2*WIDTH-1:0]         mul_prdct_i,
   output logic                       busy_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MUL_LAT + 1);
   localparam logic [IW:0]         NR     = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]       LAST   = IW'(NUM_REQ - 1);
   localparam logic [IW-1:0]       ONE_IW = IW'(1);
   localparam logic [CW-1:0]       ONE_C  = CW'(1);
   localparam logic [NUM_REQ-1:0]  ONE_R  = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      grant_id;
   logic [CW-1:0]      cnt;

   logic               found;
   logic [NUM_REQ-1:0] rot;
   logic [IW-1:0]      off;
   logic [IW:0]        sum;
   logic [IW-1:0]      win;
   logic [IW-1:0]      nxt_ptr;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;

   // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit.
   assign rot = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr);
   assign found = |req_valid_i;

   always_comb begin
      off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
   end

   assign sum     = {1'b0, rr_ptr} + {1'b0, off};
   assign win     = (sum >= NR) ? IW'(sum - NR) : sum[IW-1:0];
   assign nxt_ptr = (win == LAST) ? '0 : win + ONE_IW;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win == IW'(k)) begin
            sel_a = req_mltplr_i[k*WIDTH +: WIDTH];
            sel_b = req_mltplcnd_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign req_ready_o = (state == IDLE && found && !rst_i) ? (ONE_R << win) : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant_id       <= '0;
         cnt            <= '0;
         rsp_valid_o    <= '0;
         rsp_prdct_o    <= '0;
         mul_mltplr_o   <= '0;
         mul_mltplcnd_o <= '0;
         busy_o         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  mul_mltplr_o   <= sel_a;
                  mul_mltplcnd_o <= sel_b;
                  grant_id       <= win;
                  cnt            <= CW'(MUL_LAT);
                  rr_ptr         <= nxt_ptr;
                  busy_o         <= 1'b1;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - ONE_C;
               if (cnt == ONE_C) begin
                  rsp_prdct_o <= mul_prdct_i;
                  rsp_valid_o <= ONE_R << grant_id;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i[grant_id]) begin
                  rsp_valid_o <= '0;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rad4_mul_arbiter.sv
// Random and directed checks of rad4_mul_arbiter against a transaction model.
module tb_rad4_mul_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int PW = 2 * W;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_a, req_b;
   logic [PW-1:0]  prdct, mul_p;
   logic [W-1:0]   mul_a, mul_b;
   logic           busy;

   logic [N-1:0]   d3_valid, d3_ready, d3_rsp_valid, d3_rsp_ready;
   logic [N*W-1:0] d3_a, d3_b;
   logic [PW-1:0]  d3_prdct, d3_mul_p;
   logic [W-1:0]   d3_mul_a, d3_mul_b;
   logic           d3_busy;

   int nvec = 0;
   int nerr = 0;
   int rr_m = 0;
   int cyc = 0;
   int acc_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PW-1:0] smul(logic [W-1:0] x, logic [W-1:0] y);
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      return PW'(sx * sy);
   endfunction

   assign mul_p    = smul(mul_a, mul_b);
   assign d3_mul_p = smul(d3_mul_a, d3_mul_b);

   rad4_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_mltplr_i(req_a), .req_mltplcnd_i(req_b),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_prdct_o(prdct),
      .mul_mltplr_o(mul_a), .mul_mltplcnd_o(mul_b),
      .mul_prdct_i(mul_p), .busy_o(busy)
   );

   rad4_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(3)) dut3 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(d3_valid), .req_ready_o(d3_ready),
      .req_mltplr_i(d3_a), .req_mltplcnd_i(d3_b),
      .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(d3_rsp_ready),
      .rsp_prdct_o(d3_prdct),
      .mul_mltplr_o(d3_mul_a), .mul_mltplcnd_o(d3_mul_b),
      .mul_prdct_i(d3_mul_p), .busy_o(d3_busy)
   );

   // Requester rule: a pending request holds valid and operands.
   for (genvar i = 0; i < N; i++) begin : g_hold
      assert property (@(posedge clk) disable iff (rst)
         req_valid[i] && !req_ready[i] |=>
            req_valid[i] && $stable(req_a[i*W +: W]) && $stable(req_b[i*W +: W]));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rop();
      case ($urandom_range(7))
         0: return 8'h80;
         1: return 8'h7F;
         2: return 8'h00;
         3: return 8'hFF;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
      req_valid[i] = 1'b1;
      req_a[i*W +: W] = x;
      req_b[i*W +: W] = y;
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(rr_m + k) % N]) return (rr_m + k) % N;
      end
      return -1;
   endfunction

   // Called just after a negedge in IDLE; returns at the next IDLE negedge.
   // mode: 0 requester drops, 1 requester re-issues, 2 random traffic.
   task automatic run_op(input int hold, input int mode, input int exp_p = -1);
      int g;
      logic [N-1:0] oh;
      logic [W-1:0] ea, eb;
      #1;
      g = pick();
      if (g < 0) begin
         chk("no_req_ready", req_ready, 0);
         @(negedge clk);
         return;
      end
      oh = '0;
      oh[g] = 1'b1;
      chk("grant", req_ready, oh);
      chk("idle_busy", busy, 0);
      chk("idle_rsp", rsp_valid, 0);
      ea = req_a[g*W +: W];
      eb = req_b[g*W +: W];
      acc_cyc = cyc;
      rr_m = (g + 1) % N;
      @(negedge clk);
      if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) set_req(g, rop(), rop());
      else req_valid[g] = 1'b0;
      if (mode == 2) begin
         for (int i = 0; i < N; i++) begin
            if (i != g && !req_valid[i] && $urandom_range(2) == 0) set_req(i, rop(), rop());
         end
      end
      rsp_ready = N'($urandom);
      rsp_ready[g] = (hold == 0);
      #1;
      chk("wait_ready", req_ready, 0);
      chk("wait_busy", busy, 1);
      chk("wait_mltplr", mul_a, ea);
      chk("wait_mltplcnd", mul_b, eb);
      chk("wait_rsp", rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_prdct", prdct, smul(ea, eb));
      if (exp_p >= 0) chk("rsp_const", prdct, exp_p);
      chk("rsp_no_ready", req_ready, 0);
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         rsp_ready = N'($urandom);
         rsp_ready[g] = 1'b0;
         #1;
         chk("hold_valid", rsp_valid, oh);
         chk("hold_prdct", prdct, smul(ea, eb));
         chk("hold_ready", req_ready, 0);
         chk("hold_busy", busy, 1);
      end
      if (hold > 0) rsp_ready[g] = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      rr_m = 0;
   endtask

   // Abort requester ab in WAIT, then serve the requesters in 'after'.
   task automatic abort_op(input int ab, input logic [N-1:0] after);
      set_req(ab, rop(), rop());
      #1;
      chk("ab_grant", req_ready, N'(1) << pick());
      @(negedge clk);
      req_valid[ab] = 1'b0;
      #1;
      chk("ab_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("ab_ready", req_ready, 0);
      chk("ab_rsp", rsp_valid, 0);
      chk("ab_prdct", prdct, 0);
      chk("ab_mltplr", mul_a, 0);
      chk("ab_mltplcnd", mul_b, 0);
      chk("ab_busy0", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      rr_m = 0;
      for (int i = 0; i < N; i++) begin
         if (after[i]) set_req(i, rop(), rop());
      end
      run_op(0, 0);
   endtask

   initial begin
      int last_acc, ph;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = '0;
      d3_valid = '0;
      d3_a = '0;
      d3_b = '0;
      d3_rsp_ready = '1;

      #1 rst = 1'b1;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_prdct", prdct, 0);
      chk("rst_mltplr", mul_a, 0);
      chk("rst_mltplcnd", mul_b, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_none_ready", req_ready, 0);
      @(negedge clk);
      #1;
      chk("idle_none_busy", busy, 0);
      chk("idle_none_rsp", rsp_valid, 0);
      @(negedge clk);

      set_req(1, 8'hFB, 8'h08);
      run_op(0, 0, 'hFFD8);

      rsp_ready = '1;
      set_req(2, 8'h80, 8'h80);
      run_op(0, 0, 'h4000);
      set_req(3, 8'h80, 8'h7F);
      run_op(0, 0, 'hC080);
      set_req(3, 8'h00, 8'hFF);
      run_op(0, 0, 'h0000);

      for (int i = 0; i < N; i++) set_req(i, W'(8'h11 * (i + 1)), W'(8'hF3 - 8'(i)));
      last_acc = 0;
      ph = 0;
      for (int n = 0; n < 7; n++) begin
         int hold;
         hold = (n == 6) ? 5 : 0;
         if (n == 6) chk("rr_bp_target", pick(), 2);
         run_op(hold, 1);
         if (n > 0) chk("rr_rate", acc_cyc - last_acc, 3);
         last_acc = acc_cyc;
      end

      for (int n = 0; n < 60; n++) begin
         if (req_valid == '0) set_req($urandom_range(N - 1), rop(), rop());
         run_op($urandom_range(3), 2);
      end

      do_reset();
      abort_op(2, 4'b1000);
      abort_op(2, 4'b1010);
      run_op(0, 0);

      d3_valid = 4'b0100;
      d3_a = 32'h0007_0000;
      d3_b = 32'h00FD_0000;
      #1;
      chk("l3_grant", d3_ready, 4'b0100);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         d3_valid = '0;
         #1;
         chk("l3_mltplr", d3_mul_a, 8'h07);
         chk("l3_mltplcnd", d3_mul_b, 8'hFD);
         chk("l3_wait_rsp", d3_rsp_valid, 0);
         chk("l3_wait_busy", d3_busy, 1);
      end
      @(negedge clk);
      #1;
      chk("l3_rsp_valid", d3_rsp_valid, 4'b0100);
      chk("l3_prdct", d3_prdct, 16'hFFEB);
      @(negedge clk);
      #1;
      chk("l3_done", d3_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
